// File: rtl/vga_fill_ctrl.sv
// Rectangle-fill engine and single write-port arbiter for the 80x60 framebuffer.
// Latency: CPU write 1 cycle; fill pixels from cycle n+2 after START. CPU writes stall the engine one cycle each.
module vga_fill_ctrl #(
    parameter int H_PIX = 80,
    parameter int V_PIX = 60
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_WE,
    input  logic [12:0] CPU_WA,
    input  logic [7:0]  CPU_WD,
    input  logic        CMD_START,
    input  logic [6:0]  CMD_X0,
    input  logic [5:0]  CMD_Y0,
    input  logic [6:0]  CMD_X1,
    input  logic [5:0]  CMD_Y1,
    input  logic [7:0]  CMD_COLOR,
    output logic        FB_WE,
    output logic [12:0] FB_WA,
    output logic [7:0]  FB_WD,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam logic [6:0] X_LIM = 7'(H_PIX);
    localparam logic [5:0] Y_LIM = 6'(V_PIX);
    localparam logic [6:0] X_MAX = 7'(H_PIX - 1);
    localparam logic [5:0] Y_MAX = 6'(V_PIX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [6:0]  x0_q, x0_d;
    logic [6:0]  x1_q, x1_d;
    logic [5:0]  y1_q, y1_d;
    logic [7:0]  color_q, color_d;
    logic        fb_we_q, fb_we_d;
    logic [12:0] fb_wa_q, fb_wa_d;
    logic [7:0]  fb_wd_q, fb_wd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        cmd_bad;
    logic [6:0]  x1_clamp;
    logic [5:0]  y1_clamp;

    // Validity uses the raw X1/Y1; only the accepted end point is clamped.
    assign cmd_bad  = (CMD_X0 > CMD_X1) || (CMD_Y0 > CMD_Y1) ||
                      (CMD_X0 >= X_LIM) || (CMD_Y0 >= Y_LIM);
    assign x1_clamp = (CMD_X1 > X_MAX) ? X_MAX : CMD_X1;
    assign y1_clamp = (CMD_Y1 > Y_MAX) ? Y_MAX : CMD_Y1;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        fb_we_d = 1'b0;
        fb_wa_d = fb_wa_q;
        fb_wd_d = fb_wd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (CPU_WE) begin
            fb_we_d = 1'b1;
            fb_wa_d = CPU_WA;
            fb_wd_d = CPU_WD;
        end

        case (state_q)
            IDLE: begin
                if (CMD_START) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = FILL;
                        x_d     = CMD_X0;
                        y_d     = CMD_Y0;
                        x0_d    = CMD_X0;
                        x1_d    = x1_clamp;
                        y1_d    = y1_clamp;
                        color_d = CMD_COLOR;
                    end
                end
            end
            FILL: begin
                // CPU owns the port this edge; engine simply holds its position.
                if (!CPU_WE) begin
                    fb_we_d = 1'b1;
                    fb_wa_d = {y_q, x_q};
                    fb_wd_d = color_q;
                    if (x_q == x1_q) begin
                        if (y_q == y1_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            x_d = x0_q;
                            y_d = y_q + 6'd1;
                        end
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == FILL);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            fb_we_q <= 1'b0;
            fb_wa_q <= '0;
            fb_wd_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            fb_we_q <= fb_we_d;
            fb_wa_q <= fb_wa_d;
            fb_wd_q <= fb_wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign FB_WE = fb_we_q;
    assign FB_WA = fb_wa_q;
    assign FB_WD = fb_wd_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Directed bench for vga_fill_ctrl: each step drives inputs, advances one edge, then checks outputs.
module tb_vga_fill_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_WE;
    logic [12:0] CPU_WA;
    logic [7:0]  CPU_WD;
    logic        CMD_START;
    logic [6:0]  CMD_X0;
    logic [5:0]  CMD_Y0;
    logic [6:0]  CMD_X1;
    logic [5:0]  CMD_Y1;
    logic [7:0]  CMD_COLOR;
    logic        FB_WE;
    logic [12:0] FB_WA;
    logic [7:0]  FB_WD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    vga_fill_ctrl #(.H_PIX(80), .V_PIX(60)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_WE(CPU_WE), .CPU_WA(CPU_WA), .CPU_WD(CPU_WD),
        .CMD_START(CMD_START), .CMD_X0(CMD_X0), .CMD_Y0(CMD_Y0),
        .CMD_X1(CMD_X1), .CMD_Y1(CMD_Y1), .CMD_COLOR(CMD_COLOR),
        .FB_WE(FB_WE), .FB_WA(FB_WA), .FB_WD(FB_WD),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {FB_WE, BUSY, DONE, ERR}.
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {12'd0, FB_WE, BUSY, DONE, ERR}, {12'd0, exp});
    endtask

    task automatic chk_pix(input string tag, input logic [12:0] wa, input logic [7:0] wd);
        chk({tag, "_wa"}, {3'd0, FB_WA}, {3'd0, wa});
        chk({tag, "_wd"}, {8'd0, FB_WD}, {8'd0, wd});
    endtask

    task automatic set_cmd(input logic [6:0] x0, input logic [5:0] y0,
                           input logic [6:0] x1, input logic [5:0] y1, input logic [7:0] c);
        CMD_START = 1'b1;
        CMD_X0 = x0; CMD_Y0 = y0; CMD_X1 = x1; CMD_Y1 = y1; CMD_COLOR = c;
    endtask

    logic [12:0] ras [6];

    initial begin
        ras[0] = 13'h00A; ras[1] = 13'h00B; ras[2] = 13'h00C;
        ras[3] = 13'h08A; ras[4] = 13'h08B; ras[5] = 13'h08C;

        RST = 1'b1; CPU_WE = 1'b0; CPU_WA = '0; CPU_WD = '0;
        CMD_START = 1'b0; CMD_X0 = '0; CMD_Y0 = '0; CMD_X1 = '0; CMD_Y1 = '0; CMD_COLOR = '0;
        tick(); tick();
        chk_flags("reset_flags", 4'b0000);
        chk_pix("reset", 13'h0000, 8'h00);
        RST = 1'b0;
        tick();
        chk_flags("post_reset_idle", 4'b0000);

        // 1x1 fill at (5,3)
        set_cmd(7'd5, 6'd3, 7'd5, 6'd3, 8'hE0);
        tick();
        CMD_START = 1'b0;
        chk_flags("one_n1", 4'b0100);
        tick();
        chk_flags("one_n2", 4'b1010);
        chk_pix("one_pix", 13'h0185, 8'hE0);
        tick();
        chk_flags("one_n3", 4'b0000);

        // 3x2 raster, with an invalid START issued mid-fill and command inputs scrambled
        set_cmd(7'd10, 6'd0, 7'd12, 6'd1, 8'h55);
        tick();
        CMD_START = 1'b0;
        CMD_X0 = 7'd40; CMD_X1 = 7'd41; CMD_Y0 = 6'd9; CMD_Y1 = 6'd9; CMD_COLOR = 8'h11;
        chk_flags("ras_n1", 4'b0100);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) set_cmd(7'd20, 6'd0, 7'd10, 6'd0, 8'h77);
            if (i == 2) CMD_START = 1'b0;
            tick();
            chk_flags($sformatf("ras_flags%0d", i), (i == 5) ? 4'b1010 : 4'b1100);
            chk_pix($sformatf("ras%0d", i), ras[i], 8'h55);
        end
        tick();
        chk_flags("ras_end", 4'b0000);

        // Same 3x2 with one CPU write after the first pixel
        set_cmd(7'd10, 6'd0, 7'd12, 6'd1, 8'h66);
        tick();
        CMD_START = 1'b0;
        chk_flags("col_n1", 4'b0100);
        tick();
        chk_pix("col0", 13'h00A, 8'h66);
        CPU_WE = 1'b1; CPU_WA = 13'h1FFF; CPU_WD = 8'h1C;
        tick();
        CPU_WE = 1'b0;
        chk_flags("col_cpu_flags", 4'b1100);
        chk_pix("col_cpu", 13'h1FFF, 8'h1C);
        for (int i = 1; i < 6; i++) begin
            tick();
            chk_flags($sformatf("col_flags%0d", i), (i == 5) ? 4'b1010 : 4'b1100);
            chk_pix($sformatf("col%0d", i), ras[i], 8'h66);
        end
        tick();
        chk_flags("col_end", 4'b0000);

        // Rejections: X0>X1, Y0>Y1, X0 off-screen, Y0 off-screen
        set_cmd(7'd20, 6'd0, 7'd10, 6'd0, 8'hFF);
        tick();
        CMD_START = 1'b0;
        chk_flags("rej_x", 4'b0001);
        tick();
        chk_flags("rej_x_clear", 4'b0000);
        set_cmd(7'd0, 6'd5, 7'd3, 6'd2, 8'hFF);
        tick();
        chk_flags("rej_y", 4'b0001);
        set_cmd(7'd80, 6'd0, 7'd90, 6'd0, 8'hFF);
        tick();
        chk_flags("rej_xlim", 4'b0001);
        set_cmd(7'd0, 6'd60, 7'd1, 6'd63, 8'hFF);
        tick();
        CMD_START = 1'b0;
        chk_flags("rej_ylim", 4'b0001);
        tick();
        chk_flags("rej_idle", 4'b0000);

        // Clamp at the bottom-right corner
        set_cmd(7'd78, 6'd59, 7'd127, 6'd63, 8'h3C);
        tick();
        CMD_START = 1'b0;
        chk_flags("clamp_n1", 4'b0100);
        tick();
        chk_flags("clamp_f0", 4'b1100);
        chk_pix("clamp0", 13'h1DCE, 8'h3C);
        tick();
        chk_flags("clamp_f1", 4'b1010);
        chk_pix("clamp1", 13'h1DCF, 8'h3C);
        tick();
        chk_flags("clamp_end", 4'b0000);

        // CPU write alone in IDLE, then CPU write together with START
        CPU_WE = 1'b1; CPU_WA = 13'h0ABC; CPU_WD = 8'h5A;
        tick();
        chk_flags("cpu_idle", 4'b1000);
        chk_pix("cpu_idle", 13'h0ABC, 8'h5A);
        CPU_WA = 13'h0001; CPU_WD = 8'hC3;
        set_cmd(7'd0, 6'd0, 7'd0, 6'd0, 8'h03);
        tick();
        CPU_WE = 1'b0; CMD_START = 1'b0;
        chk_flags("both_n1", 4'b1100);
        chk_pix("both_cpu", 13'h0001, 8'hC3);
        tick();
        chk_flags("both_n2", 4'b1010);
        chk_pix("both_eng", 13'h0000, 8'h03);

        // Reset during a full-screen fill after three pixels
        set_cmd(7'd0, 6'd0, 7'd79, 6'd59, 8'hFF);
        tick();
        CMD_START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pix($sformatf("full%0d", i), 13'(i), 8'hFF);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_flags("rst_mid", 4'b0000);
        tick();
        chk_flags("rst_after", 4'b0000);
        set_cmd(7'd0, 6'd1, 7'd1, 6'd1, 8'h81);
        tick();
        CMD_START = 1'b0;
        chk_flags("re_n1", 4'b0100);
        tick();
        chk_flags("re_f0", 4'b1100);
        chk_pix("re0", 13'h0080, 8'h81);
        tick();
        chk_flags("re_f1", 4'b1010);
        chk_pix("re1", 13'h0081, 8'h81);
        tick();
        chk_flags("re_end", 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
